hazard_sequencer: RTL and testbench

// - Central stall/flush controller for the i2d, d2e, e2m and m2w pipeline registers and the PC.
// - Arbitrates d-cache miss, i-cache miss, branch mispredict and load-use hazards each cycle.
// - Holds a mispredict redirect that arrives during an i-cache fill and replays it once the fill ends.
// - Runs a miss-duration watchdog.

---
 rtl/hazard_sequencer.sv | 150 +++++++++++++++
 tb/tb_hazard_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// Pipeline stall/flush sequencer: arbitrates d-cache miss, mispredict, load-use and i-cache miss hazards.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_sequencer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MISS_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ic_miss,
    input  logic                  dc_miss,
    input  logic                  ex_mispredict,
    input  logic [ADDR_WIDTH-1:0] ex_recovery_target,
    input  logic                  ex_is_load,
    input  logic [4:0]            ex_rw_addr,
    input  logic                  dec_uses_rs,
    input  logic                  dec_uses_rt,
    input  logic [4:0]            dec_rs_addr,
    input  logic [4:0]            dec_rt_addr,
    output logic                  pc_stall,
    output logic                  pc_redirect,
    output logic [ADDR_WIDTH-1:0] redirect_target,
    output logic                  i2d_stall,
    output logic                  d2e_stall,
    output logic                  e2m_stall,
    output logic                  m2w_stall,
    output logic                  i2d_flush,
    output logic                  d2e_flush,
    output logic                  e2m_flush,
    output logic                  m2w_flush,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_events,
    output logic [31:0]           perf_load_use,
`endif
    output logic                  hang_err
);

    localparam int CNT_W = $clog2(MISS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MISS_TIMEOUT);

    typedef enum logic [1:0] {RUN, D_MISS, REDIR_PEND} state_t;

    state_t                state, state_next;
    logic                  pend_saved, pend_saved_next;
    logic [ADDR_WIDTH-1:0] tgt_q, tgt_next;
    logic [CNT_W-1:0]      miss_cnt, miss_cnt_next;
    logic                  load_use, lu_bubble, eff_pend, any_miss;

    assign load_use = ex_is_load && (ex_rw_addr != 5'd0) &&
                      ((dec_uses_rs && (dec_rs_addr == ex_rw_addr)) ||
                       (dec_uses_rt && (dec_rt_addr == ex_rw_addr)));

    // A D_MISS entered from REDIR_PEND resumes the pending redirect as soon as the miss clears.
    assign eff_pend = (state == REDIR_PEND) || ((state == D_MISS) && pend_saved);
    assign any_miss = ic_miss || dc_miss;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a signal unassigned (no latches).
        pc_stall        = 1'b0;
        pc_redirect     = 1'b0;
        redirect_target = tgt_q;
        {i2d_stall, d2e_stall, e2m_stall, m2w_stall} = 4'b0000;
        {i2d_flush, d2e_flush, e2m_flush, m2w_flush} = 4'b0000;
        state_next      = RUN;
        pend_saved_next = 1'b0;
        tgt_next        = tgt_q;
        lu_bubble       = 1'b0;

        if (rst) begin
            {i2d_flush, d2e_flush, e2m_flush, m2w_flush} = 4'b1111;
            redirect_target = '0;
        end else if (dc_miss) begin
            pc_stall = 1'b1;
            {i2d_stall, d2e_stall, e2m_stall} = 3'b111;
            m2w_flush       = 1'b1;
            state_next      = D_MISS;
            pend_saved_next = eff_pend;
        end else if (eff_pend) begin
            {i2d_flush, d2e_flush} = 2'b11;
            if (ic_miss) begin
                pc_stall   = 1'b1;
                state_next = REDIR_PEND;
                if (ex_mispredict)
                    tgt_next = ex_recovery_target;
            end else begin
                pc_redirect     = 1'b1;
                redirect_target = ex_mispredict ? ex_recovery_target : tgt_q;
            end
        end else if (ex_mispredict) begin
            {i2d_flush, d2e_flush} = 2'b11;
            if (ic_miss) begin
                pc_stall   = 1'b1;
                tgt_next   = ex_recovery_target;
                state_next = REDIR_PEND;
            end else begin
                pc_redirect     = 1'b1;
                redirect_target = ex_recovery_target;
            end
        end else if (load_use) begin
            pc_stall  = 1'b1;
            i2d_stall = 1'b1;
            d2e_flush = 1'b1;
            lu_bubble = 1'b1;
        end else if (ic_miss) begin
            pc_stall  = 1'b1;
            i2d_flush = 1'b1;
        end
    end

    always_comb begin
        miss_cnt_next = '0;
        if (any_miss)
            miss_cnt_next = (miss_cnt == CNT_MAX) ? miss_cnt : miss_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state      <= RUN;
            pend_saved <= 1'b0;
            tgt_q      <= '0;
            miss_cnt   <= '0;
            hang_err   <= 1'b0;
        end else begin
            state      <= state_next;
            pend_saved <= pend_saved_next;
            tgt_q      <= tgt_next;
            miss_cnt   <= miss_cnt_next;
            hang_err   <= hang_err || (miss_cnt_next == CNT_MAX);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
            perf_load_use     <= '0;
        end else begin
            if (pc_stall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            if (pc_redirect && (perf_flush_events != '1))
                perf_flush_events <= perf_flush_events + 32'd1;
            if (lu_bubble && (perf_load_use != '1))
                perf_load_use <= perf_load_use + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Scoreboard bench for hazard_sequencer: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_sequencer;

    localparam int AW = 32;
    localparam int MT = 4;

    logic          clk = 1'b0;
    logic          rst, ic_miss, dc_miss, ex_mispredict, ex_is_load;
    logic [AW-1:0] ex_recovery_target;
    logic [4:0]    ex_rw_addr, dec_rs_addr, dec_rt_addr;
    logic          dec_uses_rs, dec_uses_rt;
    logic          pc_stall, pc_redirect, hang_err;
    logic [AW-1:0] redirect_target;
    logic          i2d_stall, d2e_stall, e2m_stall, m2w_stall;
    logic          i2d_flush, d2e_flush, e2m_flush, m2w_flush;

    always #5 clk = ~clk;

    hazard_sequencer #(.ADDR_WIDTH(AW), .MISS_TIMEOUT(MT)) dut (
        .clk(clk), .rst(rst), .ic_miss(ic_miss), .dc_miss(dc_miss),
        .ex_mispredict(ex_mispredict), .ex_recovery_target(ex_recovery_target),
        .ex_is_load(ex_is_load), .ex_rw_addr(ex_rw_addr),
        .dec_uses_rs(dec_uses_rs), .dec_uses_rt(dec_uses_rt),
        .dec_rs_addr(dec_rs_addr), .dec_rt_addr(dec_rt_addr),
        .pc_stall(pc_stall), .pc_redirect(pc_redirect), .redirect_target(redirect_target),
        .i2d_stall(i2d_stall), .d2e_stall(d2e_stall), .e2m_stall(e2m_stall), .m2w_stall(m2w_stall),
        .i2d_flush(i2d_flush), .d2e_flush(d2e_flush), .e2m_flush(e2m_flush), .m2w_flush(m2w_flush),
        .hang_err(hang_err)
    );

    typedef struct {
        string         name;
        logic          pc_stall;
        logic          pc_redirect;
        logic          chk_tgt;
        logic [AW-1:0] tgt;
        logic [3:0]    st;
        logic [3:0]    fl;
        logic          hang;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_cnt   = 0;
    logic m_hang  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents a response mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check({e.name, ".pc_stall"}, 64'(pc_stall), 64'(e.pc_stall));
                check({e.name, ".pc_redirect"}, 64'(pc_redirect), 64'(e.pc_redirect));
                if (e.chk_tgt)
                    check({e.name, ".target"}, 64'(redirect_target), 64'(e.tgt));
                check({e.name, ".stall"}, 64'({i2d_stall, d2e_stall, e2m_stall, m2w_stall}), 64'(e.st));
                check({e.name, ".flush"}, 64'({i2d_flush, d2e_flush, e2m_flush, m2w_flush}), 64'(e.fl));
                check({e.name, ".hang_err"}, 64'(hang_err), 64'(e.hang));
            end
        end
    end

    task automatic set_lu(input logic ld, input logic [4:0] rw, input logic urs, input logic [4:0] rs,
                          input logic urt, input logic [4:0] rt);
        ex_is_load  = ld;
        ex_rw_addr  = rw;
        dec_uses_rs = urs;
        dec_rs_addr = rs;
        dec_uses_rt = urt;
        dec_rt_addr = rt;
    endtask

    // One clock cycle: drive inputs, queue the expectation, advance the miss-watchdog model.
    task automatic cyc(input string name, input logic r, input logic ic, input logic dc, input logic mp,
                       input logic [AW-1:0] t, input logic e_pcs, input logic e_red,
                       input logic [AW-1:0] e_tgt, input logic [3:0] e_st, input logic [3:0] e_fl);
        exp_t e;
        rst = r; ic_miss = ic; dc_miss = dc; ex_mispredict = mp; ex_recovery_target = t;
        e.name = name; e.pc_stall = e_pcs; e.pc_redirect = e_red; e.chk_tgt = e_red | r;
        e.tgt = e_tgt; e.st = e_st; e.fl = e_fl; e.hang = m_hang;
        sb.push_back(e);
        if (r) begin
            m_cnt = 0; m_hang = 1'b0;
        end else if (ic | dc) begin
            if (m_cnt < MT) m_cnt++;
            if (m_cnt == MT) m_hang = 1'b1;
        end else begin
            m_cnt = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ic_miss = 0; dc_miss = 0; ex_mispredict = 0; ex_recovery_target = '0;
        set_lu(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        cyc("reset0", 1, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b1111);
        cyc("reset1", 1, 0, 1, 1, 32'h1234,     0, 0, 0, 4'b0000, 4'b1111);
        cyc("idle",   0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);

        cyc("mp_run", 0, 0, 0, 1, 32'h0040_0100, 0, 1, 32'h0040_0100, 4'b0000, 4'b1100);
        cyc("idle2",  0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);

        // Mispredict during i-cache fill: 4 stall cycles then replay (also trips the MT=4 watchdog).
        cyc("mp_ic0", 0, 1, 0, 1, 32'h0040_0200, 1, 0, 0, 4'b0000, 4'b1100);
        cyc("pend1",  0, 1, 0, 0, 0,            1, 0, 0, 4'b0000, 4'b1100);
        cyc("pend2",  0, 1, 0, 0, 0,            1, 0, 0, 4'b0000, 4'b1100);
        cyc("pend3",  0, 1, 0, 0, 0,            1, 0, 0, 4'b0000, 4'b1100);
        cyc("replay", 0, 0, 0, 0, 0,            0, 1, 32'h0040_0200, 4'b0000, 4'b1100);
        cyc("after",  0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);
        cyc("rst_a",  1, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b1111);

        // A second mispredict while pending replaces the latched target.
        cyc("ovw_a",  0, 1, 0, 1, 32'h0000_0A00, 1, 0, 0, 4'b0000, 4'b1100);
        cyc("ovw_b",  0, 1, 0, 1, 32'h0000_0B00, 1, 0, 0, 4'b0000, 4'b1100);
        cyc("ovw_rpl",0, 0, 0, 0, 0,            0, 1, 32'h0000_0B00, 4'b0000, 4'b1100);

        set_lu(1, 8, 0, 0, 1, 8);
        cyc("lu_rt",  0, 0, 0, 0, 0,            1, 0, 0, 4'b1000, 4'b0100);
        cyc("lu_rt2", 0, 0, 0, 0, 0,            1, 0, 0, 4'b1000, 4'b0100);
        set_lu(1, 0, 0, 0, 1, 0);
        cyc("lu_r0",  0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);
        set_lu(1, 5, 1, 5, 0, 5);
        cyc("lu_rs",  0, 0, 0, 0, 0,            1, 0, 0, 4'b1000, 4'b0100);
        set_lu(1, 8, 1, 7, 0, 8);
        cyc("lu_none",0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);
        set_lu(0, 8, 0, 0, 1, 8);
        cyc("no_load",0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);

        set_lu(1, 8, 0, 0, 1, 8);
        cyc("mp_gt_lu", 0, 0, 0, 1, 32'h0000_0C40, 0, 1, 32'h0000_0C40, 4'b0000, 4'b1100);
        cyc("lu_gt_ic", 0, 1, 0, 0, 0,            1, 0, 0, 4'b1000, 4'b0100);
        set_lu(0, 0, 0, 0, 0, 0);
        cyc("ic_only",  0, 1, 0, 0, 0,            1, 0, 0, 4'b0000, 4'b1000);
        cyc("idle3",    0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);

        // D-cache miss masks a mispredict held in EX; redirect issues once it clears.
        for (int i = 0; i < 5; i++)
            cyc("dmiss", 0, 0, 1, 1, 32'h0000_0D00, 1, 0, 0, 4'b1110, 4'b0001);
        cyc("dm_redir", 0, 0, 0, 1, 32'h0000_0D00, 0, 1, 32'h0000_0D00, 4'b0000, 4'b1100);
        cyc("rst_b",    1, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b1111);

        // D-cache miss inside REDIR_PEND returns to the pending redirect.
        cyc("pd_mp",  0, 1, 0, 1, 32'h0000_0E00, 1, 0, 0, 4'b0000, 4'b1100);
        cyc("pd_dm",  0, 1, 1, 0, 0,            1, 0, 0, 4'b1110, 4'b0001);
        cyc("pd_ic",  0, 1, 0, 0, 0,            1, 0, 0, 4'b0000, 4'b1100);
        cyc("pd_rpl", 0, 0, 0, 0, 0,            0, 1, 32'h0000_0E00, 4'b0000, 4'b1100);
        cyc("idle4",  0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);

        // Watchdog: 3 miss cycles stay below the limit, 4 set the sticky error.
        for (int i = 0; i < 3; i++)
            cyc("wd3", 0, 1, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b1000);
        cyc("wd_clr", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        for (int i = 0; i < 4; i++)
            cyc("wd4", 0, 1, 0, 0, 0, 1, 0, 0, 4'b0000, 4'b1000);
        cyc("wd_hold1", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("wd_hold2", 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);
        cyc("wd_rst",   1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b1111);
        cyc("wd_gone",  0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000);

        // Reset during REDIR_PEND discards the redirect.
        cyc("rp_mp",   0, 1, 0, 1, 32'h0000_0F00, 1, 0, 0, 4'b0000, 4'b1100);
        cyc("rp_rst",  1, 1, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b1111);
        cyc("rp_none", 0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);
        cyc("rp_none2",0, 0, 0, 0, 0,            0, 0, 0, 4'b0000, 4'b0000);

        repeat (2) @(posedge clk);
        check("sb_drain", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
